// File: rtl/core_pkg.sv
// Shared core definitions: XLEN, reset PC, NOP encoding and the fetch FSM states.
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; serves as the decode instruction buffer and the request PC tag queue.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_s;
  logic             pop_s;
  logic             full_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    if (ptr == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return ptr + PW'(1);
    end
  endfunction

  assign full_s   = (count_r == CW'(DEPTH));
  assign empty    = (count_r == {CW{1'b0}});
  assign pop_s    = pop && !empty;
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign push_s   = push && (!full_s || pop_s);
  assign pop_data = mem_r[rd_ptr_r];
  assign count    = count_r;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch PC register, credit-limited imem request issue, redirect squash and the
// instruction buffer toward decode.
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH      = 2,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] next_pc,
  input  logic            redirect,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            fetch_misaligned
);

  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e      state_r;
  fetch_state_e      state_nxt_s;
  logic [XLEN-1:0]   pc_r;
  logic [XLEN-1:0]   pc_nxt_s;
  logic [CW-1:0]     outstanding_s;
  logic [CW-1:0]     discard_r;
  logic [CW-1:0]     discard_nxt_s;
  logic [FCW-1:0]    fifo_count_s;
  logic              misaligned_r;
  logic              misaligned_nxt_s;
  logic              redirect_s;
  logic              credit_s;
  logic              req_valid_s;
  logic              accept_s;
  logic              pc_load_s;
  logic              rsp_s;
  logic              rsp_keep_s;
  logic              tag_empty_s;
  logic              instr_empty_s;
  logic [XLEN-1:0]   tag_pc_s;
  logic [2*XLEN-1:0] head_s;

  // Redirects are meaningless before the first fetch, so BOOT ignores them.
  assign redirect_s  = redirect && (state_r != BOOT);
  // The outstanding count is the tag queue occupancy; every accepted request owns one tag.
  assign credit_s    = (int'(outstanding_s) < MAX_OUTSTANDING) &&
                       ((int'(outstanding_s) + int'(fifo_count_s)) < FIFO_DEPTH);
  assign req_valid_s = (state_r == RUN) && credit_s && !redirect;
  assign accept_s    = req_valid_s && imem_req_ready;
  assign pc_load_s   = redirect_s || accept_s;
  assign rsp_s       = imem_rsp_valid && !tag_empty_s;
  assign rsp_keep_s  = rsp_s && (discard_r == {CW{1'b0}}) && !redirect_s;

  assign pc_out           = pc_r;
  assign pc_plus4         = pc_r + XLEN'(4);
  assign imem_req_valid   = req_valid_s;
  assign imem_req_addr    = pc_r;
  assign if_valid         = !instr_empty_s;
  assign if_pc            = head_s[2*XLEN-1:XLEN];
  assign if_instr         = instr_empty_s ? NOP_INSTR : head_s[XLEN-1:0];
  assign fetch_misaligned = misaligned_r;

  fetch_fifo #(
    .WIDTH(XLEN),
    .DEPTH(MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (1'b0),
    .push     (accept_s),
    .push_data(pc_r),
    .pop      (rsp_s),
    .pop_data (tag_pc_s),
    .empty    (tag_empty_s),
    .count    (outstanding_s)
  );

  fetch_fifo #(
    .WIDTH(2 * XLEN),
    .DEPTH(FIFO_DEPTH)
  ) u_instr_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_s),
    .push     (rsp_keep_s),
    .push_data({tag_pc_s, imem_rsp_data}),
    .pop      (if_ready),
    .pop_data (head_s),
    .empty    (instr_empty_s),
    .count    (fifo_count_s)
  );

  // FSM next state, PC select and sticky misalignment flag.
  always_comb begin
    state_nxt_s      = state_r;
    misaligned_nxt_s = misaligned_r;
    pc_nxt_s         = pc_load_s ? next_pc : pc_r;
    case (state_r)
      BOOT: begin
        state_nxt_s = RUN;
      end
      RUN: begin
        if (pc_load_s && is_misaligned(next_pc)) begin
          state_nxt_s      = HALT;
          misaligned_nxt_s = 1'b1;
        end else begin
          state_nxt_s = RUN;
        end
      end
      HALT: begin
        if (redirect_s && !is_misaligned(next_pc)) begin
          state_nxt_s      = RUN;
          misaligned_nxt_s = 1'b0;
        end else begin
          state_nxt_s = HALT;
        end
      end
      default: begin
        state_nxt_s = BOOT;
      end
    endcase
  end

  // A redirect marks every request still in flight as stale, minus the one answered this cycle.
  always_comb begin
    discard_nxt_s = discard_r;
    if (redirect_s) begin
      discard_nxt_s = outstanding_s - CW'(rsp_s);
    end else if (rsp_s && (discard_r != {CW{1'b0}})) begin
      discard_nxt_s = discard_r - CW'(1);
    end else begin
      discard_nxt_s = discard_r;
    end
  end

  // Architectural fetch state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= BOOT;
      pc_r         <= RESET_PC;
      discard_r    <= {CW{1'b0}};
      misaligned_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      discard_r    <= discard_nxt_s;
      misaligned_r <= misaligned_nxt_s;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed table, hand-written corner sequences and a
// randomized run against a queue-based reference model of fetch, memory and decode.
module tb_fetch_stage;

  localparam int          FIFO_DEPTH = 2;
  localparam int          MAX_OUT    = 2;
  localparam logic [31:0] RST_PC     = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] next_pc = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] pc_out, pc_plus4, imem_req_addr, if_instr, if_pc;
  logic        imem_req_valid, if_valid, fetch_misaligned;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        if_ready = 1'b0;

  fetch_stage #(
    .RESET_PC(RST_PC),
    .FIFO_DEPTH(FIFO_DEPTH),
    .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst), .next_pc(next_pc), .redirect(redirect),
    .pc_out(pc_out), .pc_plus4(pc_plus4),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .fetch_misaligned(fetch_misaligned)
  );

  always #5 clk = ~clk;

  // Reference model: requests in flight (with due cycle and stale mark) and PCs queued for decode.
  typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
  req_t        mq[$];
  logic [31:0] dq[$];
  logic [31:0] m_pc;
  bit          m_boot, m_halt, m_mis;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  bit          exp_req_v, do_rsp_v, redir_v, rdy_v, ifr_v;
  logic [31:0] tgt_v;
  int          lat_v;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[29:0], 2'b11} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle's inputs on the falling edge and compare outputs against the model.
  task automatic drive(input bit redir, input logic [31:0] tgt, input bit rdy, input bit ifr,
                       input bit rsp_en, input int lat, input bit junk);
    @(negedge clk);
    rst            = 1'b0;
    redirect       = redir;
    next_pc        = redir ? tgt : pc_plus4;
    imem_req_ready = rdy;
    if_ready       = ifr;
    do_rsp_v       = rsp_en && (mq.size() > 0) && (mq.size() > 0 ? mq[0].due <= cyc : 1'b0);
    imem_rsp_valid = do_rsp_v || junk;
    imem_rsp_data  = do_rsp_v ? instr_of(mq[0].addr) : 32'hDEAD_BEEF;
    redir_v = redir; tgt_v = tgt; rdy_v = rdy; ifr_v = ifr; lat_v = lat;
    #1;
    exp_req_v = !m_boot && !m_halt && !redir && (mq.size() < MAX_OUT) &&
                (mq.size() + dq.size() < FIFO_DEPTH);
    chk("pc_out", pc_out, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req_v});
    if (exp_req_v) chk("req_addr", imem_req_addr, m_pc);
    chk("if_valid", {31'b0, if_valid}, {31'b0, dq.size() > 0});
    if (dq.size() > 0) begin
      chk("if_pc", if_pc, dq[0]);
      chk("if_instr", if_instr, instr_of(dq[0]));
    end
    chk("misaligned", {31'b0, fetch_misaligned}, {31'b0, m_mis});
  endtask

  // Advance the model across the rising edge using the inputs stored by drive.
  task automatic commit();
    req_t e;
    bit   redir_eff;
    redir_eff = redir_v && !m_boot;
    if (ifr_v && dq.size() > 0) void'(dq.pop_front());
    if (do_rsp_v) begin
      e = mq.pop_front();
      if (!e.stale && !redir_eff) dq.push_back(e.addr);
    end
    if (redir_eff) begin
      dq.delete();
      foreach (mq[i]) mq[i].stale = 1'b1;
      m_pc   = tgt_v;
      m_mis  = (tgt_v[1:0] != 2'b00);
      m_halt = m_mis;
    end else if (exp_req_v && rdy_v) begin
      e.addr = m_pc; e.due = cyc + lat_v; e.stale = 1'b0;
      mq.push_back(e);
      m_pc = m_pc + 32'd4;
    end
    m_boot = 1'b0;
    @(posedge clk);
    cyc++;
  endtask

  task automatic step(input bit redir, input logic [31:0] tgt, input bit rdy, input bit ifr,
                      input bit rsp_en, input int lat);
    drive(redir, tgt, rdy, ifr, rsp_en, lat, 1'b0);
    commit();
  endtask

  // Reset for one edge, optionally with a late response on the bus; the boot cycle follows.
  task automatic do_reset(input bit late);
    @(negedge clk);
    rst            = 1'b1;
    redirect       = 1'b0;
    imem_rsp_valid = late;
    imem_rsp_data  = 32'hBAD0_0000;
    @(posedge clk);
    cyc++;
    mq.delete(); dq.delete();
    m_pc = RST_PC; m_boot = 1'b1; m_halt = 1'b0; m_mis = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1, late);
    commit();
  endtask

  typedef struct {
    bit redir; logic [31:0] tgt;
    bit exp_req; logic [31:0] exp_pc; bit exp_ifv; logic [31:0] exp_ifpc; bit exp_mis;
  } vec_t;
  vec_t tbl[11];

  initial begin
    bit found;
    bit redir;
    logic [31:0] tgt;

    tbl[0]  = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0};
    tbl[1]  = '{1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   1'b0};
    tbl[2]  = '{1'b0, 32'h0,   1'b1, 32'h4,   1'b0, 32'h0,   1'b0};
    tbl[3]  = '{1'b0, 32'h0,   1'b0, 32'h8,   1'b1, 32'h0,   1'b0};
    tbl[4]  = '{1'b1, 32'h102, 1'b0, 32'h8,   1'b1, 32'h4,   1'b0};
    tbl[5]  = '{1'b0, 32'h0,   1'b0, 32'h102, 1'b0, 32'h0,   1'b1};
    tbl[6]  = '{1'b0, 32'h0,   1'b0, 32'h102, 1'b0, 32'h0,   1'b1};
    tbl[7]  = '{1'b1, 32'h200, 1'b0, 32'h102, 1'b0, 32'h0,   1'b1};
    tbl[8]  = '{1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0,   1'b0};
    tbl[9]  = '{1'b0, 32'h0,   1'b1, 32'h204, 1'b0, 32'h0,   1'b0};
    tbl[10] = '{1'b0, 32'h0,   1'b0, 32'h208, 1'b1, 32'h200, 1'b0};

    // Directed table: boot, 1-cycle memory stream, misaligned redirect, HALT, resume at 0x200.
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    mq.delete(); dq.delete();
    m_pc = RST_PC; m_boot = 1'b1; m_halt = 1'b0; m_mis = 1'b0;
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].redir, tbl[i].tgt, 1'b1, 1'b1, 1'b1, 1, 1'b0);
      chk($sformatf("tbl%0d_req", i), {31'b0, imem_req_valid}, {31'b0, tbl[i].exp_req});
      chk($sformatf("tbl%0d_pc", i), pc_out, tbl[i].exp_pc);
      chk($sformatf("tbl%0d_ifv", i), {31'b0, if_valid}, {31'b0, tbl[i].exp_ifv});
      if (tbl[i].exp_ifv) chk($sformatf("tbl%0d_ifpc", i), if_pc, tbl[i].exp_ifpc);
      chk($sformatf("tbl%0d_mis", i), {31'b0, fetch_misaligned}, {31'b0, tbl[i].exp_mis});
      commit();
    end

    // Decode stalls for 10+ cycles: buffer fills, requests stop, nothing is lost on release.
    do_reset(1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1, 1'b0);
    chk("bp_req_stalled", {31'b0, imem_req_valid}, 32'd0);
    chk("bp_buffer_valid", {31'b0, if_valid}, 32'd1);
    commit();

    // Reset with a full buffer and a late response on the bus.
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1);

    // 3-cycle memory, redirect to 0x100 with two requests in flight.
    do_reset(1'b0);
    for (int i = 0; i < 10 && mq.size() < 2; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 3);
    step(1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 3);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 3, 1'b0);
    chk("redir_flush_empty", {31'b0, if_valid}, 32'd0);
    commit();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 3, 1'b0);
      if (if_valid) begin
        found = 1'b1;
        chk("redir_first_pc", if_pc, 32'h100);
      end
      commit();
    end
    chk("redir_timeout", {31'b0, found}, 32'd1);

    // Redirect coinciding with a response; then reset with two requests in flight.
    do_reset(1'b0);
    for (int i = 0; i < 10 && mq.size() < 2; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1);
    step(1'b1, 32'h300, 1'b1, 1'b1, 1'b1, 1);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1, 1'b0);
    chk("same_cycle_discard", {30'b0, dut.discard_r}, mq.size());
    commit();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1, 1'b0);
      if (if_valid) begin
        found = 1'b1;
        chk("same_cycle_first_pc", if_pc, 32'h300);
      end
      commit();
    end
    chk("same_cycle_timeout", {31'b0, found}, 32'd1);
    for (int i = 0; i < 10 && mq.size() < 2; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 3);
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1);

    // PC wrap at the top of the address space.
    step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1, 1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      redir = m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      tgt   = $urandom & 32'h0000_FFFC;
      if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 49) == 0) tgt = 32'hFFFF_FFFC;
      step(redir, tgt, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(1, 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
